// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR decision controller.
package sar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_STROBE,
    S_WAIT,
    S_DONE
  } sar_state_t;

  localparam int unsigned N_BITS_DEF     = 8;
  localparam int unsigned SETTLE_CYC_DEF = 1;
  localparam int unsigned COMP_LAT_DEF   = 1;

  // Comparator polarity: this level means input >= DAC, so the trial bit stays set.
  localparam logic DEC_KEEP = 1'b1;

endpackage

// File: rtl/sar_cycle_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
module sar_cycle_timer
  import sar_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/sar_decision_ctrl.sv
// SAR back end: strobes the comparator once per bit and resolves the DAC code MSB-first.
//
// state    | meaning
// S_IDLE   | waiting for start, dac_code holds
// S_SETTLE | DAC settling for SETTLE_CYC cycles
// S_STROBE | comp_en pulse
// S_WAIT   | comparator latency; decision sampled on the final edge
// S_DONE   | valid pulse, result fresh
module sar_decision_ctrl
  import sar_pkg::*;
#(
  parameter int N_BITS     = N_BITS_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int COMP_LAT   = COMP_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              decision,
  output logic              comp_en,
  output logic [N_BITS-1:0] dac_code,
  output logic [N_BITS-1:0] result,
  output logic              valid,
  output logic              busy
);

  localparam int IW   = $clog2(N_BITS);
  localparam int TMAX = (SETTLE_CYC > COMP_LAT) ? SETTLE_CYC : COMP_LAT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]     SETTLE_LD = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]     WAIT_LD   = TW'(COMP_LAT - 1);
  localparam logic [IW-1:0]     IDX_TOP   = IW'(N_BITS - 1);
  localparam logic [N_BITS-1:0] MIDSCALE  = {1'b1, {(N_BITS-1){1'b0}}};

  sar_state_t        r_state, w_state_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic [N_BITS-1:0] r_dac, w_dac_nxt;
  logic [N_BITS-1:0] r_result, w_result_nxt;
  logic              w_tmr_load;
  logic [TW-1:0]     w_tmr_val;
  logic              w_tmr_tc;

  // One timer serves both SETTLE and WAIT; it is reloaded on entry to each phase.
  sar_cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_tc       (w_tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= IDX_TOP;
      r_dac    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_dac    <= w_dac_nxt;
      r_result <= w_result_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_dac_nxt    = r_dac;
    w_result_nxt = r_result;
    w_tmr_load   = 1'b0;
    w_tmr_val    = SETTLE_LD;

    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_state_nxt = S_SETTLE;
            w_dac_nxt   = MIDSCALE;
            w_idx_nxt   = IDX_TOP;
            w_tmr_load  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_SETTLE: begin
          if (w_tmr_tc) w_state_nxt = S_STROBE;
        end
        S_STROBE: begin
          w_state_nxt = S_WAIT;
          w_tmr_load  = 1'b1;
          w_tmr_val   = WAIT_LD;
        end
        S_WAIT: begin
          if (w_tmr_tc) begin
            if (decision != DEC_KEEP) w_dac_nxt[r_idx] = 1'b0;
            if (r_idx != '0) begin
              w_dac_nxt[r_idx - 1'b1] = 1'b1;
              w_idx_nxt   = r_idx - 1'b1;
              w_state_nxt = S_SETTLE;
              w_tmr_load  = 1'b1;
            end else begin
              w_result_nxt = w_dac_nxt;
              w_state_nxt  = S_DONE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign comp_en  = (r_state == S_STROBE);
  assign valid    = (r_state == S_DONE);
  assign busy     = (r_state == S_SETTLE) || (r_state == S_STROBE) || (r_state == S_WAIT);
  assign dac_code = r_dac;
  assign result   = r_result;

endmodule

// File: tb/tb_sar_decision_ctrl.sv
// Scoreboard bench for sar_decision_ctrl: an ideal comparator against a random input level.
module tb_sar_decision_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       decision;
  logic       comp_en, valid, busy;
  logic [7:0] dac_code, result;
  logic [7:0] vin = 8'h00;

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t       q_strobe[$];
  exp_t       q_valid[$];
  exp_t       e_mon;
  logic [7:0] last_res = 8'h00;

  sar_decision_ctrl #(.N_BITS(8), .SETTLE_CYC(1), .COMP_LAT(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .decision (decision),
    .comp_en  (comp_en),
    .dac_code (dac_code),
    .result   (result),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Ideal comparator: vin_p is the sampled level, vin_n the DAC output.
  assign decision = (vin >= dac_code);

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at edge %0d", name, act, req, edge_n);
    end
  endfunction

  // Binary search toward v: trial k keeps the top k bits of v and sets the next one.
  function automatic void push_conv(int e0, logic [7:0] v, int nstrobe, bit with_valid);
    exp_t t;
    for (int k = 0; k < nstrobe; k++) begin
      int hi;
      hi = (int'(v) >> (8 - k)) << (8 - k);
      t.cyc = e0 + 1 + 3 * k;
      t.val = 8'(hi | (1 << (7 - k)));
      q_strobe.push_back(t);
    end
    if (with_valid) begin
      t.cyc = e0 + 24;
      t.val = v;
      q_valid.push_back(t);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      while (q_strobe.size() > 0 && q_strobe[0].cyc < edge_n) begin
        check("strobe_missing", 32'(edge_n), 32'(q_strobe[0].cyc));
        void'(q_strobe.pop_front());
      end
      while (q_valid.size() > 0 && q_valid[0].cyc < edge_n) begin
        check("valid_missing", 32'(edge_n), 32'(q_valid[0].cyc));
        void'(q_valid.pop_front());
      end
      if (comp_en) begin
        if (q_strobe.size() == 0) begin
          check("strobe_unexpected", 32'(comp_en), 32'(0));
        end else begin
          e_mon = q_strobe.pop_front();
          check("strobe_cycle", 32'(edge_n), 32'(e_mon.cyc));
          check("strobe_dac", 32'(dac_code), 32'(e_mon.val));
        end
      end
      if (valid) begin
        if (q_valid.size() == 0) begin
          check("valid_unexpected", 32'(valid), 32'(0));
        end else begin
          e_mon = q_valid.pop_front();
          check("valid_cycle", 32'(edge_n), 32'(e_mon.cyc));
          check("result", 32'(result), 32'(e_mon.val));
        end
      end
    end
  end

  task automatic wait_to(int target);
    for (int i = 0; i < 200 && edge_n < target; i++) @(negedge clk);
    check("wait_bound", 32'(edge_n >= target), 32'(1));
  endtask

  task automatic run_conv(logic [7:0] v, bit noisy);
    int e0;
    int busy_cnt;
    bit got;
    vin = v;
    @(negedge clk);
    start = 1'b1;
    e0 = edge_n + 1;
    push_conv(e0, v, 8, 1'b1);
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (busy) busy_cnt++;
      if (valid) got = 1'b1;
      if (!got) begin
        start = (noisy && (edge_n - e0) < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("conv_completed", 32'(got), 32'(1));
    check("busy_length", 32'(busy_cnt), 32'(24));
    repeat (2) @(negedge clk);
    check("result_hold", 32'(result), 32'(v));
    last_res = v;
  endtask

  initial begin
    int e0;
    logic [7:0] v1, v2;

    #2 rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      vin   = 8'($urandom);
      #1 check("reset_outputs", 32'({comp_en, dac_code, result, valid, busy}), 32'(0));
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_outputs", 32'({comp_en, dac_code, result, valid, busy}), 32'(0));
    end

    run_conv(8'hFF, 1'b0);
    run_conv(8'h00, 1'b0);
    run_conv(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) run_conv(8'($urandom), i[0]);

    // abort during the third WAIT: sampling edge suppressed, partial code held
    vin = 8'hA5;
    @(negedge clk);
    start = 1'b1;
    e0 = edge_n + 1;
    push_conv(e0, 8'hA5, 3, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_to(e0 + 8);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_comp_en", 32'(comp_en), 32'(0));
    check("abort_dac_partial", 32'(dac_code), 32'(8'hA0));
    repeat (30) @(negedge clk);
    check("abort_result_kept", 32'(result), 32'(last_res));

    // abort together with start in IDLE keeps the block idle
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle", 32'(busy), 32'(0));

    // asynchronous reset mid-conversion
    vin = 8'($urandom);
    @(negedge clk);
    start = 1'b1;
    e0 = edge_n + 1;
    push_conv(e0, vin, 2, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_to(e0 + 5);
    rst_n = 1'b0;
    #1 check("async_reset", 32'({comp_en, dac_code, result, valid, busy}), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_reset_result", 32'(result), 32'(0));

    // back-to-back: start held through DONE
    v1 = 8'($urandom);
    v2 = 8'($urandom);
    vin = v1;
    @(negedge clk);
    start = 1'b1;
    e0 = edge_n + 1;
    push_conv(e0, v1, 8, 1'b1);
    push_conv(e0 + 25, v2, 8, 1'b1);
    wait_to(e0 + 25);
    start = 1'b0;
    vin = v2;
    wait_to(e0 + 50);
    repeat (3) @(negedge clk);
    check("b2b_result", 32'(result), 32'(v2));

    check("strobe_queue_drained", 32'(q_strobe.size()), 32'(0));
    check("valid_queue_drained", 32'(q_valid.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sar_decision_ctrl.md
# sar_decision_ctrl

Successive-approximation controller that consumes the dynamic comparator's `decision` output and drives the capacitive-DAC code, one bit per comparison. It strobes the comparator, waits a fixed latency, samples `decision`, and resolves the result MSB-first. It is the digital back end behind the comparator in the ADC slice: comparator `vin_p` = sampled input, `vin_n` = DAC output.

## Interface
- `N_BITS`, default 8: conversion resolution; ≥ 2.
- `SETTLE_CYC`, default 1: cycles the DAC is allowed to settle before each strobe; ≥ 1.
- `COMP_LAT`, default 1: cycles from the strobe cycle until `decision` is valid; ≥ 1.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  conversion request; sampled only in IDLE and DONE.
- `abort`  in  1  synchronous cancel; has priority over everything except reset.
- `decision`  in  1  comparator output; 1 means input ≥ DAC level. Sampled only in the last WAIT cycle.
- `comp_en`  out  1  comparator strobe; one-cycle pulse per bit.
- `dac_code`  out  N_BITS  trial code driven to the DAC.
- `result`  out  N_BITS  last completed conversion; holds until the next completion.
- `valid`  out  1  one-cycle pulse when `result` updates.
- `busy`  out  1  high in SETTLE, STROBE and WAIT.

## Operation
- Reset values: `comp_en`=0, `dac_code`=0, `result`=0, `valid`=0, `busy`=0, state IDLE, bit index N_BITS-1.
- **IDLE**
  - Output: `busy`=0.
  - Transition: `start`=1 → `dac_code` ← 1<<(N_BITS-1) (midscale), idx ← N_BITS-1, go to SETTLE.
  - Otherwise `dac_code` holds its value.
- **SETTLE**
  - Lasts SETTLE_CYC cycles, then goes to STROBE.
- **STROBE**
  - `comp_en`=1 for exactly this one cycle, then goes to WAIT.
- **WAIT**
  - Lasts COMP_LAT cycles. At the clock edge ending the last WAIT cycle, `decision` is sampled:
    - `decision`=0 → clear `dac_code`[idx].
    - If idx>0: set `dac_code`[idx-1], decrement idx, go to SETTLE.
    - If idx=0: `result` ← resolved code, go to DONE.
  - The DAC code and result update on the same edge.
- **DONE**
  - Outputs: `valid`=1, `busy`=0, for one cycle.
  - `start`=1 here → immediate new conversion (enters SETTLE next cycle with midscale). Otherwise → IDLE.
- **Ignored inputs**
  - `start` while `busy`=1 is ignored.
  - `decision` is ignored outside the sampling edge.
- **abort**
  - Asserted in any state: next state IDLE, `comp_en`=0, no `valid`.
  - `result` keeps its old value. `dac_code` holds the partial value.
  - `abort` and `start` together in IDLE/DONE → stay IDLE.
- **Reset mid-conversion:** all outputs take their reset values immediately (asynchronously). No `valid` is produced for the interrupted conversion.
- **Counters:** all counters wrap-free and sized $clog2 of their maximum plus one.

## Timing
- Per-bit period T = SETTLE_CYC + 1 + COMP_LAT cycles. Default T = 3.
- `start` sampled at edge E0 → `valid` high in the cycle following edge E0 + N_BITS·T. Default: 24 cycles.
- `comp_en` strobes occur at cycle offsets SETTLE_CYC + k·T after E0, k = 0..N_BITS-1 (offset 0 is the first cycle after E0).
- `dac_code` changes only at E0 and at each sampling edge. It is stable for the full SETTLE and STROBE phases.
- Back-to-back conversions: period N_BITS·T + 1 cycles.

## Structure
- Package `sar_pkg`:
  - state enum (IDLE, SETTLE, STROBE, WAIT, DONE);
  - default parameter constants;
  - decision polarity constant `DEC_KEEP = 1'b1`.
- Sub-module `sar_cycle_timer`: loadable down-counter with a terminal-count flag. It is reused for the SETTLE and WAIT phases.
- Top level holds the FSM, the idx register and the code/result registers.

## Test plan
Defaults throughout (N_BITS=8, SETTLE_CYC=1, COMP_LAT=1).
- **Reset:** hold `rst_n`=0 with random inputs → all outputs 0. Deassert, no `start` → outputs stay 0.
- **All ones:** `decision` tied 1, `start` pulse → `comp_en` pulses at offsets 1,4,…,22; `valid` one cycle 24 cycles after E0; `result`=0xFF; `busy` high for 24 cycles.
- **All zeros:** `decision` tied 0 → `result`=0x00. `dac_code` sequence 0x80,0x40,0x20,…,0x01,0x00.
- **Input 0xA5:** bench model `decision`=(0xA5 ≥ `dac_code`) at the strobe → `dac_code` trials 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; `result`=0xA5.
- **abort and ignored start:** `abort` after the 3rd strobe → IDLE next cycle, no `valid`, `result` unchanged. `start` pulsed while busy → ignored, conversion length still 24.
- **Reset and back-to-back:** `rst_n` low mid-conversion → immediate reset values. `start` held high through DONE → second conversion begins with no IDLE cycle; second `valid` 25 cycles after the first.
